rf_gain_spi_ctl: RTL and testbench



---
 rtl/rf_gain_spi_ctl.sv | 189 ++++++++++++++++++
 tb/tb_rf_gain_spi_ctl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_gain_spi_ctl.sv
// rtl/rf_gain_spi_ctl.sv - ADL5201 gain-word SPI sequencer with break-before-make THR/BYPASS switching
module rf_gain_spi_ctl #(
    parameter int CLK_DIV      = 4,
    parameter int CS_SETUP     = 2,
    parameter int CS_HOLD      = 2,
    parameter int LATCH_CYCLES = 2,
    parameter int GAIN_MAX     = 63
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       GAIN_REQ,
    input  logic [5:0] GAIN_CODE,
    input  logic [1:0] PATH_SEL,
    output logic       BUSY,
    output logic       DONE,
    output logic       CH_AMP1_THR,
    output logic       CH_AMP1_BYPASS,
    output logic       CH_AMP2_THR,
    output logic       CH_AMP2_BYPASS,
    output logic       CH_5201_CS,
    output logic       CH_5201_SCLK,
    output logic       CH_5201_SDIO,
    output logic       CH_5201_PM,
    output logic       CH_5201_LATCH
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_BREAK, S_LATCH, S_DONE
    } state_t;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [7:0] LATCH_LAST = 8'(LATCH_CYCLES - 1);
    localparam logic [5:0] GAIN_LIMIT = 6'(GAIN_MAX);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic        half_q, half_d;
    logic [15:0] shreg_q, shreg_d;
    logic [1:0]  path_q, path_d;
    logic [1:0]  thr_q, thr_d;
    logic [1:0]  byp_q, byp_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        sdio_q, sdio_d;
    logic        latch_q, latch_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept;
    logic        frame_active;
    logic [5:0]  gain_clamped;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 8'd1;
        bit_d        = bit_q;
        half_d       = half_q;
        shreg_d      = shreg_q;
        path_d       = path_q;
        thr_d        = thr_q;
        byp_d        = byp_q;
        accept       = 1'b0;
        gain_clamped = (GAIN_CODE > GAIN_LIMIT) ? GAIN_LIMIT : GAIN_CODE;

        case (state_q)
            S_IDLE: begin
                cnt_d  = 8'd0;
                accept = GAIN_REQ;
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = 8'd0;
                    half_d  = 1'b0;
                    bit_d   = 5'd0;
                end
            end
            S_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = 8'd0;
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else if (bit_q == 5'd15) begin
                        half_d  = 1'b0;
                        state_d = S_HOLD;
                    end else begin
                        // next bit appears on SDIO together with the new low half
                        half_d  = 1'b0;
                        bit_d   = bit_q + 5'd1;
                        shreg_d = {shreg_q[14:0], 1'b0};
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_BREAK;
                    cnt_d   = 8'd0;
                end
            end
            S_BREAK: begin
                state_d = S_LATCH;
                cnt_d   = 8'd0;
            end
            S_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                accept  = GAIN_REQ;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d = S_SETUP;
            cnt_d   = 8'd0;
            shreg_d = {1'b0, 7'h00, 2'b00, gain_clamped};
            path_d  = PATH_SEL;
        end

        // open both switches for one cycle before closing the new path
        if (state_d == S_BREAK) begin
            thr_d = 2'b00;
            byp_d = 2'b00;
        end else if (state_d == S_LATCH && state_q == S_BREAK) begin
            thr_d = path_q;
            byp_d = ~path_q;
        end

        frame_active = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD);
        cs_n_d       = !frame_active;
        sclk_d       = (state_d == S_SHIFT) && half_d;
        sdio_d       = frame_active && shreg_d[15];
        latch_d      = (state_d == S_LATCH);
        busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 5'd0;
            half_q  <= 1'b0;
            shreg_q <= 16'd0;
            path_q  <= 2'b00;
            thr_q   <= 2'b00;
            byp_q   <= 2'b11;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            sdio_q  <= 1'b0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            shreg_q <= shreg_d;
            path_q  <= path_d;
            thr_q   <= thr_d;
            byp_q   <= byp_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            sdio_q  <= sdio_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign CH_AMP1_THR    = thr_q[0];
    assign CH_AMP1_BYPASS = byp_q[0];
    assign CH_AMP2_THR    = thr_q[1];
    assign CH_AMP2_BYPASS = byp_q[1];
    assign CH_5201_CS     = cs_n_q;
    assign CH_5201_SCLK   = sclk_q;
    assign CH_5201_SDIO   = sdio_q;
    assign CH_5201_PM     = 1'b1;
    assign CH_5201_LATCH  = latch_q;

endmodule

// File: tb/tb_rf_gain_spi_ctl.sv
// tb/tb_rf_gain_spi_ctl.sv - directed bench for rf_gain_spi_ctl (default and fast-divider instances)
module tb_rf_gain_spi_ctl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       req1, req2;
    logic [5:0] code1, code2;
    logic [1:0] path1, path2;
    logic       busy1, done1, a1t1, a1b1, a2t1, a2b1, cs1, sclk1, sdio1, pm1, latch1;
    logic       busy2, done2, a1t2, a1b2, a2t2, a2b2, cs2, sclk2, sdio2, pm2, latch2;

    rf_gain_spi_ctl u_dut (
        .CLK(CLK), .RST(RST), .GAIN_REQ(req1), .GAIN_CODE(code1), .PATH_SEL(path1),
        .BUSY(busy1), .DONE(done1),
        .CH_AMP1_THR(a1t1), .CH_AMP1_BYPASS(a1b1), .CH_AMP2_THR(a2t1), .CH_AMP2_BYPASS(a2b1),
        .CH_5201_CS(cs1), .CH_5201_SCLK(sclk1), .CH_5201_SDIO(sdio1),
        .CH_5201_PM(pm1), .CH_5201_LATCH(latch1)
    );

    rf_gain_spi_ctl #(.CLK_DIV(1), .GAIN_MAX(40)) u_dut_fast (
        .CLK(CLK), .RST(RST), .GAIN_REQ(req2), .GAIN_CODE(code2), .PATH_SEL(path2),
        .BUSY(busy2), .DONE(done2),
        .CH_AMP1_THR(a1t2), .CH_AMP1_BYPASS(a1b2), .CH_AMP2_THR(a2t2), .CH_AMP2_BYPASS(a2b2),
        .CH_5201_CS(cs2), .CH_5201_SCLK(sclk2), .CH_5201_SDIO(sdio2),
        .CH_5201_PM(pm2), .CH_5201_LATCH(latch2)
    );

    initial forever #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic       sel = 1'b0;
    logic       m_cs, m_sclk, m_sdio, m_latch, m_done, m_busy;
    logic [1:0] m_thr, m_byp;
    assign m_cs    = sel ? cs2    : cs1;
    assign m_sclk  = sel ? sclk2  : sclk1;
    assign m_sdio  = sel ? sdio2  : sdio1;
    assign m_latch = sel ? latch2 : latch1;
    assign m_done  = sel ? done2  : done1;
    assign m_busy  = sel ? busy2  : busy1;
    assign m_thr   = sel ? {a2t2, a1t2} : {a2t1, a1t1};
    assign m_byp   = sel ? {a2b2, a1b2} : {a2b1, a1b1};

    int          cyc = 0;
    int          n0  = 0;
    int          mk;
    logic        cs_h [512];
    logic        sclk_h [512];
    logic        busy_h [512];
    logic [3:0]  path_h [512];
    int          rises, first_rise, last_rise, latch_cnt, latch_first, latch_last;
    int          done_cnt, done_k, brk_cnt, brk_k;
    int          overlap = 0;
    logic [15:0] frame;
    logic        prev_sclk;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // records every cycle relative to n0, sampled on the falling edge
    initial forever begin
        @(negedge CLK);
        mk = cyc - n0;
        if (mk >= 0 && mk < 512) begin
            cs_h[mk]   = m_cs;
            sclk_h[mk] = m_sclk;
            busy_h[mk] = m_busy;
            path_h[mk] = {m_thr, m_byp};
        end
        if (m_sclk && !prev_sclk) begin
            rises++;
            frame = {frame[14:0], m_sdio};
            if (first_rise < 0) first_rise = mk;
            last_rise = mk;
        end
        prev_sclk = m_sclk;
        if ((m_thr & m_byp) != 2'b00) overlap++;
        if ({m_thr, m_byp} == 4'b0000) begin
            brk_cnt++;
            brk_k = mk;
        end
        if (m_latch) begin
            latch_cnt++;
            if (latch_first < 0) latch_first = mk;
            latch_last = mk;
        end
        if (m_done) begin
            done_cnt++;
            done_k = mk;
        end
    end

    task automatic clear();
        n0 = cyc;
        for (int i = 0; i < 512; i++) begin
            cs_h[i]   = 1'b1;
            sclk_h[i] = 1'b0;
            busy_h[i] = 1'b0;
            path_h[i] = 4'b0000;
        end
        rises = 0; first_rise = -1; last_rise = -1;
        latch_cnt = 0; latch_first = -1; latch_last = -1;
        done_cnt = 0; done_k = -1; brk_cnt = 0; brk_k = -1;
        frame = 16'h0000;
        prev_sclk = m_sclk;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_to(input int kk);
        while (cyc - n0 < kk) tick();
    endtask

    function automatic int cs_low_first();
        for (int i = 0; i < 512; i++) if (cs_h[i] == 1'b0) return i;
        return -1;
    endfunction

    function automatic int cs_low_last();
        for (int i = 511; i >= 0; i--) if (cs_h[i] == 1'b0) return i;
        return -1;
    endfunction

    int idle_bad;

    initial begin
        RST = 1'b1;
        req1 = 1'b0; code1 = 6'h00; path1 = 2'b00;
        req2 = 1'b0; code2 = 6'h00; path2 = 2'b00;
        clear();
        repeat (3) tick();
        check("rst_cs", cs1, 1'b1);
        check("rst_sclk_sdio", {sclk1, sdio1, latch1}, 3'b000);
        check("rst_pm", pm1, 1'b1);
        check("rst_paths", {a2t1, a1t1, a2b1, a1b1}, 4'b0011);
        check("rst_busy_done", {busy1, done1}, 2'b00);

        // idle after release with no request
        RST = 1'b0;
        clear();
        run_to(25);
        idle_bad = 0;
        for (int i = 1; i < 25; i++)
            if (cs_h[i] !== 1'b1 || sclk_h[i] !== 1'b0 || busy_h[i] !== 1'b0 || path_h[i] !== 4'b0011)
                idle_bad++;
        check("idle_hold", idle_bad, 0);
        check("idle_pm", pm1, 1'b1);

        // frame 0x2A to AMP1 thru; mid-frame input changes and a re-pulse must be ignored
        clear();
        req1 = 1'b1; code1 = 6'h2A; path1 = 2'b01;
        tick();
        req1 = 1'b0; code1 = 6'h3C; path1 = 2'b10;
        run_to(50);
        req1 = 1'b1; code1 = 6'h15;
        tick();
        req1 = 1'b0;
        run_to(200);
        check("f1_frame", frame, 16'h002A);
        check("f1_rises", rises, 16);
        check("f1_first_rise", first_rise, 7);
        check("f1_last_rise", last_rise, 127);
        check("f1_cs_first", cs_low_first(), 1);
        check("f1_cs_last", cs_low_last(), 132);
        check("f1_busy", {busy_h[1], busy_h[135], busy_h[136]}, 3'b110);
        check("f1_latch_first", latch_first, 134);
        check("f1_latch_last", latch_last, 135);
        check("f1_latch_cnt", latch_cnt, 2);
        check("f1_break", path_h[133], 4'b0000);
        check("f1_paths", path_h[134], 4'b0110);
        check("f1_done_cnt", done_cnt, 1);
        check("f1_done_k", done_k, 136);

        // path 11 then 00: single all-open cycle before both bypass
        clear();
        req1 = 1'b1; code1 = 6'h01; path1 = 2'b11;
        tick();
        req1 = 1'b0;
        run_to(150);
        check("p11_paths", path_h[140], 4'b1100);
        clear();
        req1 = 1'b1; code1 = 6'h02; path1 = 2'b00;
        tick();
        req1 = 1'b0;
        run_to(150);
        check("p00_brk_cnt", brk_cnt, 1);
        check("p00_brk_k", brk_k, 133);
        check("p00_paths", path_h[134], 4'b0011);
        check("p00_frame", frame, 16'h0002);

        // request held high through DONE: second frame starts right after
        clear();
        req1 = 1'b1; code1 = 6'h3F; path1 = 2'b10;
        run_to(137);
        req1 = 1'b0;
        run_to(290);
        check("held_cs_136", cs_h[136], 1'b1);
        check("held_cs_137", cs_h[137], 1'b0);
        check("held_done_cnt", done_cnt, 2);
        check("held_done_k", done_k, 272);
        check("held_rises", rises, 32);
        check("held_frame", frame, 16'h003F);
        check("held_paths", path_h[280], 4'b1001);

        // reset in the middle of SHIFT
        clear();
        req1 = 1'b1; code1 = 6'h11; path1 = 2'b11;
        tick();
        req1 = 1'b0;
        run_to(70);
        RST = 1'b1;
        #1;
        check("mid_rst_cs_sclk", {cs1, sclk1}, 2'b10);
        check("mid_rst_busy_latch", {busy1, latch1}, 2'b00);
        check("mid_rst_paths", {a2t1, a1t1, a2b1, a1b1}, 4'b0011);
        repeat (3) tick();
        RST = 1'b0;
        run_to(200);
        check("mid_rst_no_latch", latch_cnt, 0);
        check("mid_rst_no_done", done_cnt, 0);
        clear();
        req1 = 1'b1; code1 = 6'h05; path1 = 2'b10;
        tick();
        req1 = 1'b0;
        run_to(150);
        check("post_rst_frame", frame, 16'h0005);
        check("post_rst_done_k", done_k, 136);
        check("post_rst_paths", path_h[140], 4'b1001);

        // CLK_DIV=1, GAIN_MAX=40 instance: clamp and fast timing
        sel = 1'b1;
        #1;
        clear();
        req2 = 1'b1; code2 = 6'h3F; path2 = 2'b01;
        tick();
        req2 = 1'b0;
        run_to(60);
        check("fast_frame", frame, 16'h0028);
        check("fast_rises", rises, 16);
        check("fast_first_rise", first_rise, 4);
        check("fast_last_rise", last_rise, 34);
        check("fast_sclk_period", {sclk_h[4], sclk_h[5], sclk_h[6]}, 3'b101);
        check("fast_done_k", done_k, 40);
        check("fast_done_cnt", done_cnt, 1);
        check("fast_paths", path_h[45], 4'b0110);

        check("no_thr_byp_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
